// File: rtl/pipe_pc_ctrl.sv
// Fetch PC register and next-PC select for the IF stage, with CP0 request hold across stalls.
// Optional misaligned jr/jalr target detection is built when PC_ALIGN_CHECK_EN is defined.
module pipe_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] npc,
    input  logic        b_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] r_pc,
    input  logic        exc_req,
    input  logic        eret,
    output logic [31:0] pc,
    output logic [2:0]  pc_mux_sel,
    output logic        if_flush,
    output logic        redirect_pend,
    output logic        adel,
    output logic [31:0] badvaddr
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [2:0] SEL_J    = 3'd0;
    localparam logic [2:0] SEL_JR   = 3'd1;
    localparam logic [2:0] SEL_PC4  = 3'd2;
    localparam logic [2:0] SEL_EXC  = 3'd3;
    localparam logic [2:0] SEL_BR   = 3'd4;
    localparam logic [2:0] SEL_EPC  = 3'd5;

    state_t      state_q, state_d;
    logic        exc_pend_q, exc_pend_d;
    logic        eret_pend_q, eret_pend_d;
    logic [31:0] pc_q, pc_d;
    logic        exc, ret, misalign;
    logic [2:0]  sel;

    // Redirect priority; reset forces sequential fetch so nothing fires while rst is high.
    always_comb begin
        exc      = exc_req | exc_pend_q;
        ret      = (eret | eret_pend_q) & ~exc;
        misalign = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        misalign = jr & ~exc & ~ret & ~stall & (r_pc[1:0] != 2'b00);
`endif
        sel = SEL_PC4;
        if (rst)           sel = SEL_PC4;
        else if (exc)      sel = SEL_EXC;
        else if (ret)      sel = SEL_EPC;
        else if (misalign) sel = SEL_EXC;
        else if (jr)       sel = SEL_JR;
        else if (jump)     sel = SEL_J;
        else if (b_taken)  sel = SEL_BR;
    end

    // A stalled CP0 pulse is remembered; a newer exception always discards a pending eret.
    always_comb begin
        state_d     = state_q;
        exc_pend_d  = exc_pend_q;
        eret_pend_d = eret_pend_q;
        pc_d        = pc_q;
        if (stall) begin
            exc_pend_d  = exc_pend_q | exc_req;
            eret_pend_d = (eret_pend_q | eret) & ~exc_pend_d;
            state_d     = (exc_pend_d | eret_pend_d) ? PEND : RUN;
        end else begin
            exc_pend_d  = 1'b0;
            eret_pend_d = 1'b0;
            state_d     = RUN;
            pc_d        = npc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            exc_pend_q  <= 1'b0;
            eret_pend_q <= 1'b0;
            pc_q        <= RESET_PC;
        end else begin
            state_q     <= state_d;
            exc_pend_q  <= exc_pend_d;
            eret_pend_q <= eret_pend_d;
            pc_q        <= pc_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic        adel_q;
    logic [31:0] badvaddr_q;

    // badvaddr keeps the last offending target until the next detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            adel_q     <= 1'b0;
            badvaddr_q <= 32'h0;
        end else begin
            adel_q <= misalign;
            if (misalign) badvaddr_q <= r_pc;
        end
    end

    assign adel     = adel_q;
    assign badvaddr = badvaddr_q;
`else
    logic unused_rpc;
    assign unused_rpc = ^r_pc;
    assign adel       = 1'b0;
    assign badvaddr   = 32'h0;
`endif

    assign pc            = pc_q;
    assign pc_mux_sel    = sel;
    assign if_flush      = ~rst & ~stall & (sel != SEL_PC4);
    assign redirect_pend = exc_pend_q | eret_pend_q;

endmodule

// File: tb/tb_pipe_pc_ctrl.sv
// Scoreboard bench for pipe_pc_ctrl: expected fetch PCs are queued as stimulus is driven
// and popped after each edge. Honours PC_ALIGN_CHECK_EN for the alignment scenario.
module tb_pipe_pc_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] VEC      = 32'h8000_0180;
    localparam logic [31:0] EPC      = 32'h0040_0010;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] npc;
    logic        b_taken;
    logic        jump;
    logic        jr;
    logic [31:0] r_pc;
    logic        exc_req;
    logic        eret;
    logic [31:0] pc;
    logic [2:0]  pc_mux_sel;
    logic        if_flush;
    logic        redirect_pend;
    logic        adel;
    logic [31:0] badvaddr;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] expPcQ[$];
    logic [31:0] modelPc;
    logic [31:0] expPc;
    logic        sawEpc;

    pipe_pc_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .npc(npc), .b_taken(b_taken),
        .jump(jump), .jr(jr), .r_pc(r_pc), .exc_req(exc_req), .eret(eret),
        .pc(pc), .pc_mux_sel(pc_mux_sel), .if_flush(if_flush),
        .redirect_pend(redirect_pend), .adel(adel), .badvaddr(badvaddr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic waitEdge;
        @(posedge clk);
        #1;
    endtask

    // Advance one edge and compare pc against the oldest queued expectation.
    task automatic stepAndPop(input string name);
        waitEdge();
        checks++;
        if (expPcQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL %s: scoreboard empty, pc=%h", name, pc);
        end else begin
            expPc = expPcQ.pop_front();
            if (pc !== expPc) begin
                fails++;
                $display("[TB] FAIL %s: pc=%h required %h", name, pc, expPc);
            end
            modelPc = expPc;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; stall = 1'b0; npc = 32'hDEAD_BEEF; b_taken = 1'b0; jump = 1'b0;
        jr = 1'b0; r_pc = 32'h0; exc_req = 1'b0; eret = 1'b0;
        waitEdge();
        waitEdge();
        checks++; if (pc !== RESET_PC) begin fails++; $display("[TB] FAIL reset_pc: pc=%h required %h", pc, RESET_PC); end
        checks++; if (pc_mux_sel !== 3'd2) begin fails++; $display("[TB] FAIL reset_sel: sel=%0d required 2", pc_mux_sel); end
        checks++; if (if_flush !== 1'b0) begin fails++; $display("[TB] FAIL reset_flush: %b required 0", if_flush); end
        checks++; if (redirect_pend !== 1'b0) begin fails++; $display("[TB] FAIL reset_pend: %b required 0", redirect_pend); end
        checks++; if (adel !== 1'b0 || badvaddr !== 32'h0) begin fails++; $display("[TB] FAIL reset_adel: adel=%b badvaddr=%h required 0/0", adel, badvaddr); end
        rst = 1'b0;
        modelPc = RESET_PC;
    endtask

    task automatic test_sequential;
        for (int i = 0; i < 3; i++) begin
            npc = modelPc + 32'd4;
            expPcQ.push_back(modelPc + 32'd4);
            #1;
            checks++;
            if (pc_mux_sel !== 3'd2 || if_flush !== 1'b0) begin
                fails++;
                $display("[TB] FAIL seq_sel: sel=%0d flush=%b required 2/0", pc_mux_sel, if_flush);
            end
            stepAndPop("seq_pc");
        end
        checks++;
        if (pc !== 32'h0040_000C) begin fails++; $display("[TB] FAIL seq_final: pc=%h required 0040000c", pc); end
    endtask

    task automatic test_id_redirects;
        logic [2:0]  selTab[3];
        logic [31:0] tgtTab[3];
        selTab = '{3'd4, 3'd0, 3'd1};
        tgtTab = '{32'h0040_0100, 32'h0040_0200, 32'h0040_0300};
        for (int i = 0; i < 3; i++) begin
            b_taken = (i == 0);
            jump    = (i == 1);
            jr      = (i == 2);
            r_pc    = tgtTab[i];
            npc     = tgtTab[i];
            expPcQ.push_back(tgtTab[i]);
            #1;
            checks++;
            if (pc_mux_sel !== selTab[i] || if_flush !== 1'b1) begin
                fails++;
                $display("[TB] FAIL id_sel[%0d]: sel=%0d flush=%b required %0d/1", i, pc_mux_sel, if_flush, selTab[i]);
            end
            stepAndPop("id_pc");
        end
        b_taken = 1'b0; jump = 1'b0; jr = 1'b0;
    endtask

    task automatic test_cp0_priority;
        exc_req = 1'b1; jr = 1'b1; r_pc = 32'h0040_0400; npc = VEC;
        expPcQ.push_back(VEC);
        #1;
        checks++;
        if (pc_mux_sel !== 3'd3 || if_flush !== 1'b1) begin
            fails++;
            $display("[TB] FAIL exc_over_jr: sel=%0d flush=%b required 3/1", pc_mux_sel, if_flush);
        end
        stepAndPop("exc_pc");
        exc_req = 1'b0; jr = 1'b0;
        eret = 1'b1; npc = EPC;
        expPcQ.push_back(EPC);
        #1;
        checks++;
        if (pc_mux_sel !== 3'd5) begin fails++; $display("[TB] FAIL eret_sel: sel=%0d required 5", pc_mux_sel); end
        stepAndPop("eret_pc");
        exc_req = 1'b1; eret = 1'b1; npc = VEC;
        expPcQ.push_back(VEC);
        #1;
        checks++;
        if (pc_mux_sel !== 3'd3) begin fails++; $display("[TB] FAIL exc_eret_tie: sel=%0d required 3", pc_mux_sel); end
        stepAndPop("tie_pc");
        exc_req = 1'b0; eret = 1'b0; npc = modelPc + 32'd4;
        expPcQ.push_back(modelPc + 32'd4);
        #1;
        checks++;
        if (pc_mux_sel !== 3'd2 || redirect_pend !== 1'b0) begin
            fails++;
            $display("[TB] FAIL tie_after: sel=%0d pend=%b required 2/0", pc_mux_sel, redirect_pend);
        end
        stepAndPop("tie_after_pc");
    endtask

    task automatic test_stall_exc;
        stall = 1'b1; exc_req = 1'b1; npc = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            expPcQ.push_back(modelPc);
            #1;
            checks++;
            if (if_flush !== 1'b0) begin fails++; $display("[TB] FAIL stall_flush: %b required 0", if_flush); end
            stepAndPop("stall_hold_pc");
            exc_req = 1'b0;
            checks++;
            if (redirect_pend !== 1'b1) begin fails++; $display("[TB] FAIL stall_pend[%0d]: %b required 1", i, redirect_pend); end
        end
        stall = 1'b0; npc = VEC;
        expPcQ.push_back(VEC);
        #1;
        checks++;
        if (pc_mux_sel !== 3'd3 || if_flush !== 1'b1) begin
            fails++;
            $display("[TB] FAIL pend_apply: sel=%0d flush=%b required 3/1", pc_mux_sel, if_flush);
        end
        stepAndPop("pend_pc");
        checks++;
        if (redirect_pend !== 1'b0 || pc_mux_sel !== 3'd2) begin
            fails++;
            $display("[TB] FAIL pend_clear: pend=%b sel=%0d required 0/2", redirect_pend, pc_mux_sel);
        end
    endtask

    task automatic test_supersede;
        stall = 1'b1; eret = 1'b1; npc = 32'h1234_5678;
        expPcQ.push_back(modelPc);
        stepAndPop("sup_hold1");
        eret = 1'b0; exc_req = 1'b1;
        expPcQ.push_back(modelPc);
        stepAndPop("sup_hold2");
        exc_req = 1'b0; stall = 1'b0; npc = VEC;
        expPcQ.push_back(VEC);
        #1;
        checks++;
        if (pc_mux_sel !== 3'd3) begin fails++; $display("[TB] FAIL supersede: sel=%0d required 3", pc_mux_sel); end
        stepAndPop("sup_pc");
        npc = modelPc + 32'd4;
        #1;
        checks++;
        if (pc_mux_sel !== 3'd2 || redirect_pend !== 1'b0) begin
            fails++;
            $display("[TB] FAIL supersede_eret_dropped: sel=%0d pend=%b required 2/0", pc_mux_sel, redirect_pend);
        end
    endtask

    task automatic test_reset_mid_pend;
        stall = 1'b1; eret = 1'b1; npc = 32'h1234_5678;
        expPcQ.push_back(modelPc);
        stepAndPop("rp_hold");
        eret = 1'b0;
        checks++;
        if (redirect_pend !== 1'b1) begin fails++; $display("[TB] FAIL rp_latched: %b required 1", redirect_pend); end
        rst = 1'b1;
        expPcQ.push_back(RESET_PC);
        stepAndPop("rp_reset_pc");
        rst = 1'b0; stall = 1'b0;
        checks++;
        if (redirect_pend !== 1'b0) begin fails++; $display("[TB] FAIL rp_pend_cleared: %b required 0", redirect_pend); end
        sawEpc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            npc = modelPc + 32'd4;
            expPcQ.push_back(modelPc + 32'd4);
            #1;
            if (pc_mux_sel === 3'd5) sawEpc = 1'b1;
            stepAndPop("rp_seq_pc");
        end
        checks++;
        if (sawEpc !== 1'b0) begin fails++; $display("[TB] FAIL rp_no_eret: saw sel=5 got %b required 0", sawEpc); end
    endtask

    task automatic test_wrap;
        npc = 32'hFFFF_FFFC;
        expPcQ.push_back(32'hFFFF_FFFC);
        stepAndPop("wrap_pre");
        npc = modelPc + 32'd4;
        expPcQ.push_back(32'h0);
        stepAndPop("wrap_pc");
    endtask

    task automatic test_align;
        jr = 1'b1; r_pc = 32'h0040_0102;
`ifdef PC_ALIGN_CHECK_EN
        npc = VEC;
        expPcQ.push_back(VEC);
        #1;
        checks++;
        if (pc_mux_sel !== 3'd3 || if_flush !== 1'b1) begin
            fails++;
            $display("[TB] FAIL align_sel: sel=%0d flush=%b required 3/1", pc_mux_sel, if_flush);
        end
        stepAndPop("align_pc");
        jr = 1'b0; r_pc = 32'h0; npc = modelPc + 32'd4;
        checks++;
        if (adel !== 1'b1 || badvaddr !== 32'h0040_0102) begin
            fails++;
            $display("[TB] FAIL align_adel: adel=%b badvaddr=%h required 1/00400102", adel, badvaddr);
        end
        expPcQ.push_back(modelPc + 32'd4);
        stepAndPop("align_after_pc");
        checks++;
        if (adel !== 1'b0 || badvaddr !== 32'h0040_0102) begin
            fails++;
            $display("[TB] FAIL align_hold: adel=%b badvaddr=%h required 0/00400102", adel, badvaddr);
        end
`else
        npc = 32'h0040_0102;
        expPcQ.push_back(32'h0040_0102);
        #1;
        checks++;
        if (pc_mux_sel !== 3'd1 || if_flush !== 1'b1) begin
            fails++;
            $display("[TB] FAIL align_sel: sel=%0d flush=%b required 1/1", pc_mux_sel, if_flush);
        end
        stepAndPop("align_pc");
        jr = 1'b0; r_pc = 32'h0;
        checks++;
        if (adel !== 1'b0 || badvaddr !== 32'h0) begin
            fails++;
            $display("[TB] FAIL align_adel: adel=%b badvaddr=%h required 0/0", adel, badvaddr);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_id_redirects();
        test_cp0_priority();
        test_stall_exc();
        test_supersede();
        test_reset_mid_pend();
        test_wrap();
        test_align();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pipe_pc_ctrl.md
# pipe_pc_ctrl

Program-counter owner and next-PC selector for the IF stage. Holds the architectural fetch PC register and drives the fetch stage's `pc` and `pc_mux_sel` inputs. Loads the fetch stage's `npc` output back into that register each cycle. Arbitrates redirect requests from ID (branch/jump/jr) and CP0 (exception/eret), holds pulsed CP0 requests across pipeline stalls, and flags the wrong-path fetch for squash.

## Interface
- `RESET_PC`, 32'h0040_0000, PC value loaded by reset.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard stall; PC holds, no redirect consumed.
- `npc`  in  32  next PC from the fetch stage's mux.
- `b_taken`  in  1  level from ID: branch (beq/bne/bgez) resolved taken.
- `jump`  in  1  level from ID: j/jal.
- `jr`  in  1  level from ID: jr/jalr.
- `r_pc`  in  32  jr/jalr target from ID. Used only for the alignment check.
- `exc_req`  in  1  one-cycle pulse from CP0: take exception.
- `eret`  in  1  one-cycle pulse from CP0: return to EPC.
- `pc`  out  32  registered fetch PC.
- `pc_mux_sel`  out  3  0=j, 1=jr, 2=pc+4, 3=exception vector, 4=branch, 5=EPC; 6/7 never driven.
- `if_flush`  out  1  squash the instruction currently in IF.
- `redirect_pend`  out  1  a CP0 request is latched and waiting.
- `adel`  out  1  misaligned jr target detected (`PC_ALIGN_CHECK_EN` only).
- `badvaddr`  out  32  offending jr target (`PC_ALIGN_CHECK_EN` only).

## Operation
- States: RUN and PEND.
  - RUN → PEND: `stall`=1 while `exc_req` or `eret` is asserted. The request is latched into `exc_pend`/`eret_pend`.
  - PEND → RUN: first cycle with `stall`=0. The latched request is applied and its pend bit is cleared in the same edge.
- Effective requests:
  - exc = `exc_req` | `exc_pend`
  - ret = (`eret` | `eret_pend`) & ~exc
- Selection priority (combinational, recomputed every cycle): exc → 3, ret → 5, `jr` → 1, `jump` → 0, `b_taken` → 4, otherwise 2.
- PC load: when `stall`=0, `pc` <= `npc`. When `stall`=1, `pc` holds.
- `if_flush` = ~`stall` & (`pc_mux_sel` != 2). It is combinational, valid in the same cycle as the redirect. The IF/ID register must drop its input on the next edge.
- Simultaneous exc and eret: the exception wins and the eret is discarded (both pend bits are cleared).
- A new `exc_req` while `eret_pend` is set: the exception supersedes and `eret_pend` is cleared.
- ID-level requests (`b_taken`/`jump`/`jr`) are never latched. ID holds them stable during a stall.
- `redirect_pend` = `exc_pend` | `eret_pend`.

## Timing
- Reset values:
  - `pc`=`RESET_PC`
  - `exc_pend`=`eret_pend`=0, state RUN
  - `pc_mux_sel`=2, `if_flush`=0, `redirect_pend`=0
  - `adel`=0, `badvaddr`=0
- First fetch address after `rst` deasserts is `RESET_PC`.
- Redirect latency: request seen in cycle N with `stall`=0 → `pc` equals the target in cycle N+1. Exactly one wrong-path instruction is flushed.
- Request pulsed during a stall of length S → applied in the first unstalled cycle → `pc` equals the target one cycle later.
- `rst` mid-PEND clears both pend bits. No redirect fires after reset.
- PC arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - When `jr`=1, no higher-priority request, and `r_pc[1:0]`!=0, force `pc_mux_sel`=3 (exception vector) and assert `if_flush`.
  - `adel` is registered: high for exactly one cycle after the unstalled edge.
  - `badvaddr` <= `r_pc` on that edge and holds until the next `adel` event.
  - Under stall, no detection is made.
- `PC_ALIGN_CHECK_EN` undefined: no check is made, `adel` is tied 0 and `badvaddr` is tied 0. A misaligned target is loaded as-is.

## Test plan
- Reset → `pc`=32'h0040_0000 and `pc_mux_sel`=2. Three free-running cycles with npc=pc+4 → `pc` = 0x00400004, 0x00400008, 0x0040000C.
- `b_taken`=1, npc=0x00400100, `stall`=0 → `pc_mux_sel`=4 and `if_flush`=1 that cycle; `pc`=0x00400100 next cycle.
- `exc_req` and `jr` in the same cycle → `pc_mux_sel`=3 (not 1), `if_flush`=1.
- `exc_req` pulse during a 3-cycle stall → `redirect_pend`=1 for 3 cycles and `pc` unchanged; on the 4th cycle `pc_mux_sel`=3 and `redirect_pend` falls.
- `eret` latched under stall, then `rst` asserted mid-stall → after reset `redirect_pend`=0 and `pc`=`RESET_PC`, with no sel=5 ever seen.
- With `PC_ALIGN_CHECK_EN`: `jr`=1, `r_pc`=0x00400102 → `pc_mux_sel`=3; next cycle `adel`=1 and `badvaddr`=0x00400102. Without the macro: sel=1 and `adel` stays 0.
